// File: rtl/mcu_run_controller.sv
// Run controller: sequences core reset, counts run cycles and detects
// end of program (tohost write, PC stall, or cycle-budget timeout).
module mcu_run_controller #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int RST_CYCLES  = 2,
    parameter int MAX_CYCLES  = 1024,
    parameter int STALL_LIMIT = 4,
    parameter int CNT_W       = 16,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = 32'h0000_0FFC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              halted,
    output logic              timeout,
    output logic [DATA_W-1:0] result,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int RC_W = $clog2(RST_CYCLES + 1);
    localparam int SC_W = $clog2(STALL_LIMIT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic              core_rst_n, busy_n, done_n;
    logic              pass_n, halted_n, timeout_n;
    logic [DATA_W-1:0] result_n;
    logic [CNT_W-1:0]  cycle_count_n;
    logic [RC_W-1:0]   rst_cnt, rst_cnt_n;
    logic [SC_W-1:0]   stall_cnt, stall_cnt_n;
    logic [ADDR_W-1:0] prev_pc, prev_pc_n;
    logic              pc_valid, pc_valid_n;

    logic [CNT_W-1:0]  cnt_inc;
    logic [SC_W-1:0]   stall_next;
    logic              tohost_hit;

    assign cnt_inc    = cycle_count + CNT_W'(1);
    assign tohost_hit = mem_we && (mem_addr == TOHOST_ADDR);
    // prev_pc is meaningless on the first RUN cycle, so no compare then
    assign stall_next = (pc_valid && pc_in == prev_pc)
                      ? stall_cnt + SC_W'(1) : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            core_rst    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
            result      <= '0;
            cycle_count <= '0;
            rst_cnt     <= '0;
            stall_cnt   <= '0;
            prev_pc     <= '0;
            pc_valid    <= 1'b0;
        end else begin
            state       <= state_n;
            core_rst    <= core_rst_n;
            busy        <= busy_n;
            done        <= done_n;
            pass        <= pass_n;
            halted      <= halted_n;
            timeout     <= timeout_n;
            result      <= result_n;
            cycle_count <= cycle_count_n;
            rst_cnt     <= rst_cnt_n;
            stall_cnt   <= stall_cnt_n;
            prev_pc     <= prev_pc_n;
            pc_valid    <= pc_valid_n;
        end
    end

    always_comb begin
        state_n       = state;
        core_rst_n    = core_rst;
        busy_n        = busy;
        done_n        = done;
        pass_n        = pass;
        halted_n      = halted;
        timeout_n     = timeout;
        result_n      = result;
        cycle_count_n = cycle_count;
        rst_cnt_n     = rst_cnt;
        stall_cnt_n   = stall_cnt;
        prev_pc_n     = prev_pc;
        pc_valid_n    = pc_valid;

        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n       = S_RESET;
                    core_rst_n    = 1'b1;
                    busy_n        = 1'b1;
                    done_n        = 1'b0;
                    pass_n        = 1'b0;
                    halted_n      = 1'b0;
                    timeout_n     = 1'b0;
                    result_n      = '0;
                    cycle_count_n = '0;
                    rst_cnt_n     = '0;
                    stall_cnt_n   = '0;
                    pc_valid_n    = 1'b0;
                end
            end
            S_RESET: begin
                if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
                    state_n    = S_RUN;
                    core_rst_n = 1'b0;
                end else begin
                    rst_cnt_n = rst_cnt + RC_W'(1);
                end
            end
            S_RUN: begin
                cycle_count_n = cnt_inc;
                prev_pc_n     = pc_in;
                pc_valid_n    = 1'b1;
                stall_cnt_n   = stall_next;
                if (tohost_hit) begin
                    result_n = mem_wdata;
                    pass_n   = (mem_wdata == DATA_W'(1));
                    state_n  = S_DONE;
                end else if (stall_next == SC_W'(STALL_LIMIT)) begin
                    halted_n = 1'b1;
                    pass_n   = 1'b0;
                    state_n  = S_DONE;
                end else if (cnt_inc == CNT_W'(MAX_CYCLES)) begin
                    timeout_n = 1'b1;
                    pass_n    = 1'b0;
                    state_n   = S_DONE;
                end
                if (state_n == S_DONE) begin
                    done_n     = 1'b1;
                    busy_n     = 1'b0;
                    core_rst_n = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mcu_run_controller.sv
// Scoreboard bench for mcu_run_controller: a small core model drives PC
// and tohost writes; expected run endings are queued and compared at done.
module tb_mcu_run_controller;

    localparam int MAXC = 16;
    localparam logic [31:0] TOHOST = 32'h0000_0FFC;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] pc_in = '0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        core_rst, busy, done, pass, halted, timeout;
    logic [31:0] result;
    logic [15:0] cycle_count;

    typedef struct {
        logic        pass;
        logic        halted;
        logic        timeout;
        logic [31:0] result;
        logic [15:0] count;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    mcu_run_controller #(.MAX_CYCLES(MAXC)) dut (
        .clk(clk), .rst(rst), .start(start), .pc_in(pc_in),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_rst(core_rst), .busy(busy), .done(done), .pass(pass),
        .halted(halted), .timeout(timeout), .result(result),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b1;
        tick();
        tick();
        checks++;
        if (core_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
            cycle_count !== 16'd0 || pass !== 1'b0 || halted !== 1'b0 ||
            timeout !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL reset_values: core_rst=%b busy=%b done=%b cnt=%0d pass=%b halted=%b timeout=%b result=%h, want 1 0 0 0 0 0 0 0",
                     core_rst, busy, done, cycle_count, pass, halted, timeout, result);
        end
        start = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || core_rst !== 1'b1) begin
            errors++;
            $display("FAIL idle_hold: busy=%b core_rst=%b, want 0 1", busy, core_rst);
        end
    endtask

    task automatic start_run(input logic reset_write);
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || core_rst !== 1'b1 ||
            cycle_count !== 16'd0 || pass !== 1'b0 || halted !== 1'b0 ||
            timeout !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL start_entry: busy=%b done=%b core_rst=%b cnt=%0d pass=%b halted=%b timeout=%b result=%h, want 1 0 1 0 0 0 0 0",
                     busy, done, core_rst, cycle_count, pass, halted, timeout, result);
        end
        if (reset_write) begin
            mem_we = 1'b1;
            mem_addr = TOHOST;
            mem_wdata = 32'd1;
        end
        tick();
        checks++;
        if (core_rst !== 1'b1) begin
            errors++;
            $display("FAIL rst_hold: core_rst=%b, want 1", core_rst);
        end
        tick();
        mem_we = 1'b0;
        checks++;
        if (core_rst !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_release: core_rst=%b busy=%b, want 0 1", core_rst, busy);
        end
    endtask

    // Drive RUN cycles 1..N from the core model until done, then score.
    task automatic run_prog(input int wr_cyc, input logic [31:0] wdata,
                            input int stall_from);
        exp_t e;
        bit   seen = 1'b0;
        logic [15:0] cnt_done;
        for (int k = 1; k <= 40; k++) begin
            pc_in = (stall_from > 0 && k >= stall_from) ? 32'h40 : 32'(4 * (k - 1));
            mem_we = (k == wr_cyc);
            mem_addr = mem_we ? TOHOST : 32'h100;
            mem_wdata = wdata;
            tick();
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        mem_we = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_wait: done never rose within 40 cycles, want done=1");
        end else begin
            if (pass !== e.pass || halted !== e.halted || timeout !== e.timeout) begin
                errors++;
                $display("FAIL end_flags: pass=%b halted=%b timeout=%b, want %b %b %b",
                         pass, halted, timeout, e.pass, e.halted, e.timeout);
            end
            checks++;
            if (result !== e.result) begin
                errors++;
                $display("FAIL end_result: result=%h, want %h", result, e.result);
            end
            checks++;
            if (cycle_count !== e.count) begin
                errors++;
                $display("FAIL end_count: cycle_count=%0d, want %0d", cycle_count, e.count);
            end
            checks++;
            if (core_rst !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL end_ctrl: core_rst=%b busy=%b, want 1 0", core_rst, busy);
            end
            cnt_done = e.count;
            pc_in = pc_in + 32'd4;
            mem_we = 1'b1;
            mem_addr = TOHOST;
            mem_wdata = 32'h55;
            tick();
            mem_we = 1'b0;
            checks++;
            if (done !== 1'b1 || cycle_count !== cnt_done || result !== e.result) begin
                errors++;
                $display("FAIL done_frozen: done=%b cnt=%0d result=%h, want 1 %0d %h",
                         done, cycle_count, result, cnt_done, e.result);
            end
        end
    endtask

    task automatic test_tohost_pass();
        sb.push_back('{pass: 1'b1, halted: 1'b0, timeout: 1'b0,
                       result: 32'd1, count: 16'd10});
        start_run(1'b0);
        run_prog(10, 32'd1, 0);
    endtask

    task automatic test_tohost_fail();
        sb.push_back('{pass: 1'b0, halted: 1'b0, timeout: 1'b0,
                       result: 32'h2A, count: 16'd10});
        start_run(1'b1);
        run_prog(10, 32'h2A, 0);
    endtask

    task automatic test_halt();
        sb.push_back('{pass: 1'b0, halted: 1'b1, timeout: 1'b0,
                       result: 32'd0, count: 16'd9});
        start_run(1'b0);
        run_prog(0, 32'd0, 5);
    endtask

    task automatic test_priority();
        sb.push_back('{pass: 1'b1, halted: 1'b0, timeout: 1'b0,
                       result: 32'd1, count: 16'd9});
        start_run(1'b0);
        run_prog(9, 32'd1, 5);
    endtask

    task automatic test_timeout();
        sb.push_back('{pass: 1'b0, halted: 1'b0, timeout: 1'b1,
                       result: 32'd0, count: 16'(MAXC)});
        start_run(1'b0);
        run_prog(0, 32'd0, 0);
    endtask

    task automatic test_abort();
        start_run(1'b0);
        for (int k = 1; k <= 7; k++) begin
            pc_in = 32'(4 * (k - 1));
            if (k == 7) rst = 1'b0;
            tick();
        end
        rst = 1'b1;
        checks++;
        if (core_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
            cycle_count !== 16'd0 || pass !== 1'b0 || halted !== 1'b0 ||
            timeout !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL abort_values: core_rst=%b busy=%b done=%b cnt=%0d pass=%b halted=%b timeout=%b result=%h, want 1 0 0 0 0 0 0 0",
                     core_rst, busy, done, cycle_count, pass, halted, timeout, result);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || core_rst !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle: busy=%b core_rst=%b, want 0 1", busy, core_rst);
        end
    endtask

    task automatic test_back_to_back();
        sb.push_back('{pass: 1'b0, halted: 1'b1, timeout: 1'b0,
                       result: 32'd0, count: 16'd9});
        start_run(1'b0);
        run_prog(0, 32'd0, 5);
        sb.push_back('{pass: 1'b0, halted: 1'b0, timeout: 1'b0,
                       result: 32'd3, count: 16'd2});
        start_run(1'b0);
        run_prog(2, 32'd3, 0);
    endtask

    initial begin
        test_reset();
        test_tohost_pass();
        test_tohost_fail();
        test_halt();
        test_priority();
        test_timeout();
        test_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
